// File: rtl/lc3_pkg.sv
// Shared LC-3 memory/IO definitions: MMIO register map and controller FSM states.
package lc3_pkg;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_HOLD
  } state_e;

  function automatic logic is_mmio(input logic [15:0] addr);
    return (addr == KBSR) || (addr == KBDR) || (addr == DSR) || (addr == DDR);
  endfunction

endpackage

// File: rtl/lc3_btn_sync.sv
// Two-flop synchroniser for the raw push-button followed by a rising-edge detector.
module lc3_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  // [1:0] synchronise; [2] is the previous synchronised sample for edge detection
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], btn};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/lc3_memio_ctrl.sv
// LC-3 memory controller: sequences SRAM accesses with fixed latency, decodes the
// keyboard/display MMIO registers and raises the R bit for one cycle per access.
module lc3_memio_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mdr_out,
  output logic        ready,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_we,
  input  logic [15:0] sram_rdata,
  input  logic        btn,
  output logic [3:0]  led_out
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        mmio_q, mmio_d;
  logic        we_q, we_d;
  logic [15:0] mdr_q, mdr_d;
  logic [3:0]  led_q, led_d;
  logic        kb_ready_q, kb_ready_d;
  logic [3:0]  count_q, count_d;
  logic        btn_rise;
  logic [15:0] mmio_rdata;

  lc3_btn_sync u_btn_sync (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .rise (btn_rise)
  );

  always_comb begin
    mmio_rdata = '0;
    case (addr_q)
      KBSR:    mmio_rdata = {kb_ready_q, 15'b0};
      KBDR:    mmio_rdata = {12'b0, count_q};
      DSR:     mmio_rdata = 16'h8000;
      DDR:     mmio_rdata = {12'b0, led_q};
      default: mmio_rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    mmio_d     = mmio_q;
    we_d       = 1'b0;
    mdr_d      = mdr_q;
    led_d      = led_q;
    kb_ready_d = kb_ready_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          addr_d  = mar;
          wdata_d = mdr_in;
          wr_d    = r_w;
          mmio_d  = is_mmio(mar);
          cnt_d   = is_mmio(mar) ? 4'd0 : 4'(MEM_LATENCY - 1);
          we_d    = r_w & ~is_mmio(mar);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!wr_q) begin
            mdr_d = mmio_q ? mmio_rdata : sram_rdata;
            if (mmio_q && addr_q == KBDR) kb_ready_d = 1'b0;
          end else if (mmio_q && addr_q == DDR) begin
            led_d = wdata_q[3:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = mem_en ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!mem_en) state_d = ST_IDLE;
    endcase

    // A button edge overrides a same-cycle KBDR-read clear so no press is lost
    if (btn_rise) begin
      kb_ready_d = 1'b1;
      count_d    = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      mmio_q     <= 1'b0;
      we_q       <= 1'b0;
      mdr_q      <= '0;
      led_q      <= '0;
      kb_ready_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      mmio_q     <= mmio_d;
      we_q       <= we_d;
      mdr_q      <= mdr_d;
      led_q      <= led_d;
      kb_ready_q <= kb_ready_d;
      count_q    <= count_d;
    end
  end

  assign ready      = (state_q == ST_DONE);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we    = we_q;
  assign mdr_out    = mdr_q;
  assign led_out    = led_q;

endmodule

// File: tb/tb_lc3_memio_ctrl.sv
// Scoreboard bench for lc3_memio_ctrl: a word-level reference model predicts each
// access result, write strobe and completion cycle; a monitor checks them on ready/sram_we.
module tb_lc3_memio_ctrl;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] mar = '0;
  logic [15:0] mdr_in = '0;
  logic [15:0] mdr_out;
  logic        ready;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we;
  logic [15:0] sram_rdata = '0;
  logic        btn = 1'b0;
  logic [3:0]  led_out;

  lc3_memio_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_en     (mem_en),
    .r_w        (r_w),
    .mar        (mar),
    .mdr_in     (mdr_in),
    .mdr_out    (mdr_out),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we    (sram_we),
    .sram_rdata (sram_rdata),
    .btn        (btn),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM: read data appears one cycle after the address
  logic [15:0] sram [0:65535];
  always @(posedge clk) begin
    if (sram_we === 1'b1) sram[sram_addr] <= sram_wdata;
    sram_rdata <= sram[sram_addr];
  end

  typedef struct {
    logic        is_read;
    logic [15:0] data;
    logic [3:0]  led;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int unsigned cyc;
  } wexp_t;

  exp_t  sbq[$];
  wexp_t wq[$];

  // Reference model state
  logic [15:0] ref_mem [logic [15:0]];
  logic [3:0]  ref_led = '0;
  logic        ref_kb = 1'b0;
  logic [3:0]  ref_count = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic mmio_addr(input logic [15:0] a);
    return a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06;
  endfunction

  function automatic logic [15:0] ref_mem_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  // Monitor: every ready pulse and every write strobe must match a predicted entry
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sbq.size() == 0) chk("ready_unexpected", 32'(ready), 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ready_cycle", cyc, e.cyc);
        if (e.is_read) chk("read_data", 32'(mdr_out), 32'(e.data));
        chk("led_at_done", 32'(led_out), 32'(e.led));
      end
    end
    if (sram_we === 1'b1) begin
      if (wq.size() == 0) chk("sram_we_unexpected", 32'(sram_we), 32'd0);
      else begin
        wexp_t w;
        w = wq.pop_front();
        chk("we_cycle", cyc, w.cyc);
        chk("we_addr", 32'(sram_addr), 32'(w.addr));
        chk("we_data", 32'(sram_wdata), 32'(w.data));
      end
    end
  end

  // One complete access; mem_en stays high `hold` cycles past completion
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int unsigned hold);
    exp_t        e;
    logic        mm;
    int unsigned lat;
    mm  = mmio_addr(a);
    lat = mm ? 1 : LAT;
    @(posedge clk); #1;
    mar = a; mdr_in = d; r_w = wr; mem_en = 1'b1;
    @(posedge clk); #1;
    e.is_read = !wr;
    e.cyc     = cyc + lat;
    e.data    = '0;
    if (!wr) begin
      if (!mm)                 e.data = ref_mem_rd(a);
      else if (a == 16'hFE00)  e.data = ref_kb ? 16'h8000 : 16'h0000;
      else if (a == 16'hFE02)  begin e.data = {12'h000, ref_count}; ref_kb = 1'b0; end
      else if (a == 16'hFE04)  e.data = 16'h8000;
      else                     e.data = {12'h000, ref_led};
    end else if (!mm) begin
      ref_mem[a] = d;
      wq.push_back('{addr: a, data: d, cyc: cyc});
    end else if (a == 16'hFE06) begin
      ref_led = d[3:0];
    end
    e.led = ref_led;
    sbq.push_back(e);
    mar = 16'($urandom); mdr_in = 16'($urandom); r_w = 1'($urandom);
    repeat (lat + hold) @(posedge clk);
    #1 mem_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic press();
    @(posedge clk); #1 btn = 1'b1;
    repeat (4) @(posedge clk);
    #1 btn = 1'b0;
    repeat (4) @(posedge clk);
    ref_count = ref_count + 4'd1;
    ref_kb    = 1'b1;
  endtask

  logic [15:0] pool [0:7];

  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = '0;
    sram[16'h3000] = 16'h1234;
    ref_mem[16'h3000] = 16'h1234;
    pool[0] = 16'h3000; pool[1] = 16'h3001; pool[2] = 16'h4000; pool[3] = 16'hFE01;
    pool[4] = 16'hFE00; pool[5] = 16'hFE02; pool[6] = 16'hFE04; pool[7] = 16'hFE06;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_we", 32'(sram_we), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_wdata", 32'(sram_wdata), 32'd0);
    chk("rst_mdr", 32'(mdr_out), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);

    access(1'b0, 16'h3000, 16'h0, 0);
    access(1'b1, 16'h4000, 16'hBEEF, 5);
    access(1'b0, 16'h4000, 16'h0, 0);
    access(1'b1, 16'hFE06, 16'h000A, 0);
    chk("ddr_led", 32'(led_out), 32'hA);
    access(1'b0, 16'hFE06, 16'h0, 1);

    repeat (3) press();
    access(1'b0, 16'hFE00, 16'h0, 0);
    access(1'b0, 16'hFE02, 16'h0, 0);
    access(1'b0, 16'hFE00, 16'h0, 0);
    repeat (16) press();
    access(1'b0, 16'hFE02, 16'h0, 2);

    // Button edge lands on the KBDR completion edge: btn rises two edges before acceptance
    begin
      exp_t e;
      @(posedge clk); #1 btn = 1'b1;
      @(posedge clk); #1 mar = 16'hFE02; r_w = 1'b0; mem_en = 1'b1;
      @(posedge clk); #1;
      e.is_read = 1'b1; e.data = {12'h000, ref_count}; e.cyc = cyc + 1;
      ref_count = ref_count + 4'd1; ref_kb = 1'b1;
      e.led = ref_led;
      sbq.push_back(e);
      @(posedge clk); #1 mem_en = 1'b0;
      repeat (4) @(posedge clk);
      #1 btn = 1'b0;
      repeat (4) @(posedge clk);
    end
    access(1'b0, 16'hFE00, 16'h0, 0);

    // Reset during the second ACCESS cycle of a write
    access(1'b1, 16'hFE06, 16'h0005, 0);
    @(posedge clk); #1;
    mar = 16'h5000; mdr_in = 16'hCAFE; r_w = 1'b1; mem_en = 1'b1;
    @(posedge clk); #1;
    ref_mem[16'h5000] = 16'hCAFE;
    wq.push_back('{addr: 16'h5000, data: 16'hCAFE, cyc: cyc});
    mem_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ref_led = '0; ref_kb = 1'b0; ref_count = '0;
    @(negedge clk);
    chk("rst_mid_led", 32'(led_out), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd0);
    chk("rst_mid_we", 32'(sram_we), 32'd0);
    repeat (3) @(posedge clk);
    access(1'b0, 16'h5000, 16'h0, 0);
    access(1'b0, 16'hFE00, 16'h0, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) press();
      access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom),
             $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    chk("wq_drained", wq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lc3_memio_ctrl.md
LC3_MEMIO_CTRL -- requirements
Module: lc3_memio_ctrl

Interface
REQ-001 The block SHALL take parameter MEM_LATENCY, default 2, meaning cycles from request acceptance to SRAM completion (legal range 1..15).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_en  input  1  access request from the LC-3 datapath (MEM.EN).
REQ-005 r_w  input  1  access direction: 1 = write, 0 = read.
REQ-006 mar  input  16  access address (MAR contents).
REQ-007 mdr_in  input  16  write data (MDR contents).
REQ-008 mdr_out  output  16  read data for loading into MDR.
REQ-009 ready  output  1  R bit; high one cycle when the access completes.
REQ-010 sram_addr  output  16  SRAM word address.
REQ-011 sram_wdata  output  16  SRAM write data.
REQ-012 sram_we  output  1  SRAM write strobe.
REQ-013 sram_rdata  input  16  SRAM read data, valid one cycle after sram_addr.
REQ-014 btn  input  1  raw asynchronous push-button.
REQ-015 led_out  output  4  LED register.

Function
REQ-016 The FSM SHALL have the states IDLE, ACCESS, DONE and HOLD.
REQ-017 In IDLE with mem_en=1, the block SHALL latch mar, mdr_in and r_w, load the latency counter, and enter ACCESS.
REQ-018 For an SRAM address, the latency counter SHALL load MEM_LATENCY-1; for an MMIO address (xFE00, xFE02, xFE04, xFE06) it SHALL load 0.
REQ-019 ACCESS SHALL decrement the counter each cycle and enter DONE when the counter is 0.
REQ-020 ready SHALL be high only in DONE, so an SRAM request accepted at edge E0 raises ready during the cycle after edge E0+MEM_LATENCY, for exactly one cycle.
REQ-021 DONE SHALL go to IDLE if mem_en=0, otherwise to HOLD.
REQ-022 HOLD SHALL return to IDLE only when mem_en=0, so a held mem_en never starts a second access.
REQ-023 For an SRAM write, sram_we SHALL be high for exactly one cycle, in the first ACCESS cycle, with the latched address and data.
REQ-024 sram_addr SHALL hold the latched address from ACCESS entry through DONE.
REQ-025 For an SRAM read, mdr_out SHALL capture sram_rdata at the edge entering DONE and hold it until the next read completes.
REQ-026 MMIO accesses SHALL never assert sram_we.
REQ-027 A KBSR read SHALL return {kb_ready, 15'b0}.
REQ-028 A KBDR read SHALL return {12'b0, press_count} and clear kb_ready.
REQ-029 A DSR read SHALL return x8000, because the display is always ready.
REQ-030 A DDR read SHALL return {12'b0, led_out}.
REQ-031 A DDR write SHALL load led_out from mdr[3:0] at the edge entering DONE.
REQ-032 Writes to KBSR, KBDR and DSR SHALL be ignored.
REQ-033 btn SHALL be synchronised through 2 flops and edge-detected; each rising edge SHALL set kb_ready and increment the 4-bit press_count, which wraps 15->0.
REQ-034 If a button edge and a KBDR-read completion fall in the same cycle, kb_ready SHALL end set and the count SHALL increment.
REQ-035 mar, mdr_in and r_w changing after acceptance SHALL not affect the access in flight.

Reset
REQ-036 rst SHALL force: state IDLE, ready 0, sram_we 0, sram_addr 0, sram_wdata 0, mdr_out 0, led_out 0, kb_ready 0, press_count 0, synchroniser flops 0.
REQ-037 rst asserted mid-access SHALL abandon the access with no SRAM write issued afterwards, and ready SHALL stay low in the following cycle.

Structure
REQ-038 Package lc3_pkg SHALL hold the MMIO address constants (KBSR, KBDR, DSR, DDR) and the FSM state enum.
REQ-039 The synchroniser and edge detector SHALL be one sub-module, lc3_btn_sync (in: clk, rst, btn; out: rise pulse).

Verification
REQ-040 The bench SHALL cover: preload SRAM[x3000]=x1234, read x3000 with MEM_LATENCY=2 -> ready in the cycle after edge E0+2, mdr_out=x1234, one ready pulse.
REQ-041 The bench SHALL cover: write xBEEF to x4000, hold mem_en 5 cycles -> one sram_we pulse, one ready, no second access; read-back returns xBEEF.
REQ-042 The bench SHALL cover: DDR write x000A -> led_out=4'hA, sram_we never high; DDR read returns x000A.
REQ-043 The bench SHALL cover: 3 button presses, KBSR read -> x8000; KBDR read -> x0003; next KBSR read -> x0000; 16 presses -> count wraps.
REQ-044 The bench SHALL cover: rst asserted in ACCESS of a write -> no sram_we afterwards, ready low, led_out=0, state IDLE.
REQ-045 The bench SHALL cover: a button edge in the same cycle as a KBDR-read completion -> KBSR read afterwards returns x8000.
